ex_div_seq: RTL and testbench
=============================

EX_DIV_SEQ -- requirements
Module: ex_div_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; only 32 is verified.
REQ-002 Clock  input  1  single clock; all state updates on the rising edge.
REQ-003 nReset  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  issue a divide; sampled only in IDLE.
REQ-005 Signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with Start.
REQ-006 A  input  32  dividend; sampled with Start.
REQ-007 B  input  32  divisor; sampled with Start.
REQ-008 Flush  input  1  pipeline flush; aborts any operation in progress.
REQ-009 HiLoRead  input  1  a later instruction reads HI/LO (MFHI/MFLO).
REQ-010 Quot  output  32  quotient (LO write data).
REQ-011 Rem  output  32  remainder (HI write data).
REQ-012 Done  output  1  one-cycle pulse; Quot/Rem valid; HI/LO write enable.
REQ-013 Busy  output  1  high in every state except IDLE.
REQ-014 Stall  output  1  pipeline hold request (combinational).
REQ-015 DivZero  output  1  registered; set on the Done of a divide with B = 0.

Function
REQ-016 States SHALL be IDLE, CALC, FIX and DONE, encoded in 2 bits.
REQ-017 IDLE -> CALC SHALL occur on Start=1 with Flush=0 and B!=0; operand magnitudes, operand signs and Signed are latched, and the 6-bit step counter is set to 0.
REQ-018 IDLE -> DONE SHALL occur on Start=1 with Flush=0 and B=0, with Quot=32'hFFFFFFFF, Rem=A and DivZero=1.
REQ-019 CALC SHALL perform one restoring shift-subtract step per cycle (33-bit partial remainder), stay 32 cycles, and go to FIX when the counter reaches 31.
REQ-020 FIX SHALL apply sign correction for one cycle, then go to DONE.
  - Quot negated if the operand signs differ and Signed=1.
  - Rem takes the dividend's sign if Signed=1.
REQ-021 DONE SHALL assert Done for exactly one cycle and return to IDLE unconditionally.
REQ-022 Latency: for B!=0, Done SHALL be high on the 34th rising edge after the edge that sampled Start; for B=0, on the 1st.
REQ-023 Quot and Rem SHALL be updated only on entry to DONE, and SHALL hold their values until the next entry to DONE.
REQ-024 DivZero SHALL be updated only on entry to DONE.
REQ-025 Signed -2^31 / -1 SHALL return Quot=32'h80000000, Rem=0; no overflow flag.
REQ-026 Stall SHALL be Busy & (Start | HiLoRead): a second divide or a HI/LO read waits until after Done.
REQ-027 Start while Busy SHALL be ignored: it does not re-latch operands or restart the counter.
REQ-028 Flush in CALC or FIX SHALL force IDLE on the next edge: no Done, Quot/Rem/DivZero unchanged.
REQ-029 Flush in DONE SHALL NOT suppress Done (the result commits); the state still returns to IDLE.
REQ-030 Start and Flush in the same IDLE cycle: Flush SHALL win and no operation starts.
REQ-031 Start in the DONE cycle SHALL be ignored; the requester retries in IDLE, and Stall is asserted in that cycle.

Reset
REQ-032 nReset low SHALL immediately (asynchronously) set state=IDLE, counter=0, Quot=0, Rem=0, Done=0, DivZero=0 and all latched operands to 0; Busy and Stall therefore read 0.
REQ-033 Reset asserted mid-CALC SHALL discard the operation; after release the first Start behaves as from power-up.
REQ-034 Reset deassertion SHALL be the only synchronous concern; no operation starts on the release edge unless Start=1 is sampled there.

Verification
REQ-035 Unsigned: Start, Signed=0, A=100, B=7 -> Done at edge 34; Quot=14, Rem=2, DivZero=0; Busy high for edges 1-33 after the sampling edge.
REQ-036 Signed: A=-7 (32'hFFFFFFF9), B=2 -> Quot=-3 (32'hFFFFFFFD), Rem=-1; and A=32'h80000000, B=32'hFFFFFFFF -> Quot=32'h80000000, Rem=0.
REQ-037 Divide by zero: A=5, B=0 -> Done on the next edge; Quot=32'hFFFFFFFF, Rem=5, DivZero=1, Busy high for one cycle.
REQ-038 Hazard: Start A=50, B=5; at cycle 10 assert HiLoRead and a second Start -> Stall=1 until Done; the first result Quot=10, Rem=0 is unaffected.
REQ-039 Abort: Flush at cycle 20 of CALC -> IDLE next edge, no Done pulse, Quot/Rem keep the prior values; then Start A=9, B=3 -> Quot=3, Rem=0.
REQ-040 Async reset: nReset low at cycle 15 of CALC, mid-cycle -> Busy=0 and Quot=0 before the next edge; no Done after release.

Source files
------------

// File: rtl/ex_div_seq.sv
// Sequential restoring divider for DIV/DIVU with HI/LO commit and hazard stall.
// One shift-subtract step per cycle on operand magnitudes, followed by a
// single sign-correction cycle and a one-cycle Done pulse.
module ex_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  input  logic             HiLoRead,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             Done,
  output logic             Busy,
  output logic             Stall,
  output logic             DivZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_t           state, state_n;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] dvd;      // dividend magnitude; quotient bits shift in at the bottom
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH-1:0] rem_p;    // partial remainder, always below dvs between steps
  logic             sign_a;
  logic             sign_b;
  logic             sgn;

  logic             start_go;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign start_go = Start && !Flush;
  assign b_zero   = (B == '0);
  assign a_mag    = (Signed && A[WIDTH-1]) ? -A : A;
  assign b_mag    = (Signed && B[WIDTH-1]) ? -B : B;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  assign shifted  = {rem_p, dvd[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs};

  // Sign correction; -2^31 / -1 wraps naturally to 2^31 with zero remainder.
  assign q_fix    = (sgn && (sign_a ^ sign_b)) ? -dvd : dvd;
  assign r_fix    = (sgn && sign_a) ? -rem_p : rem_p;

  assign Done     = (state == DONE);
  assign Busy     = (state != IDLE);
  assign Stall    = Busy && (Start || HiLoRead);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state logic; Flush aborts CALC/FIX but never a committed DONE.
  // NOTE: state_n gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start_go) state_n = b_zero ? DONE : CALC;
      CALC: begin
        if (Flush)                 state_n = IDLE;
        else if (cnt == LAST_STEP) state_n = FIX;
      end
      FIX:  state_n = Flush ? IDLE : DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand latch and iterative datapath.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem_p  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      sgn    <= 1'b0;
    end else if (state == IDLE && start_go && !b_zero) begin
      cnt    <= '0;
      dvd    <= a_mag;
      dvs    <= b_mag;
      rem_p  <= '0;
      sign_a <= A[WIDTH-1];
      sign_b <= B[WIDTH-1];
      sgn    <= Signed;
    end else if (state == CALC && !Flush) begin
      cnt <= cnt + 6'd1;
      if (!diff[WIDTH]) begin
        rem_p <= diff[WIDTH-1:0];
        dvd   <= {dvd[WIDTH-2:0], 1'b1};
      end else begin
        rem_p <= shifted[WIDTH-1:0];
        dvd   <= {dvd[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Result registers: written only on entry to DONE, held otherwise.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Quot    <= '0;
      Rem     <= '0;
      DivZero <= 1'b0;
    end else if (state == IDLE && start_go && b_zero) begin
      Quot    <= '1;
      Rem     <= A;
      DivZero <= 1'b1;
    end else if (state == FIX && !Flush) begin
      Quot    <= q_fix;
      Rem     <= r_fix;
      DivZero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_div_seq.sv
// Self-checking bench for ex_div_seq: directed scenarios plus random operands
// checked against an arithmetic reference model.
module tb_ex_div_seq;

  logic        Clock;
  logic        nReset;
  logic        Start;
  logic        Signed;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        HiLoRead;
  logic [31:0] Quot;
  logic [31:0] Rem;
  logic        Done;
  logic        Busy;
  logic        Stall;
  logic        DivZero;

  int total = 0;
  int bad   = 0;

  ex_div_seq #(.WIDTH(32)) dut (
    .Clock(Clock), .nReset(nReset), .Start(Start), .Signed(Signed),
    .A(A), .B(B), .Flush(Flush), .HiLoRead(HiLoRead),
    .Quot(Quot), .Rem(Rem), .Done(Done), .Busy(Busy),
    .Stall(Stall), .DivZero(DivZero)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Reference: C-style truncating division, remainder takes dividend sign.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Issues one divide from IDLE; lat = cycles after the sampling edge until Done is seen.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output int lat, output logic done_after);
    Start = 1'b1; Signed = sg; A = a; B = b;
    step();
    Start = 1'b0;
    lat = 0;
    while (!Done && lat < 100) begin
      step();
      lat++;
    end
    q = Quot; r = Rem; dz = DivZero;
    step();
    done_after = Done;
  endtask

  task automatic test_reset();
    nReset = 1'b0; Start = 1'b0; Signed = 1'b0; A = '0; B = '0;
    Flush = 1'b0; HiLoRead = 1'b1;
    #12;
    total++;
    if ({Quot, Rem, Done, Busy, Stall, DivZero} !== 68'd0) begin
      bad++;
      $display("FAIL reset_outputs: got q=%h r=%h done=%b busy=%b stall=%b dz=%b, want all zero",
               Quot, Rem, Done, Busy, Stall, DivZero);
    end
    HiLoRead = 1'b0;
    nReset = 1'b1;
    repeat (3) step();
    total++;
    if (Busy !== 1'b0) begin
      bad++; $display("FAIL reset_release_idle: busy=%b want 0", Busy);
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r; logic dz; int lat, busy_cnt;
    Start = 1'b1; Signed = 1'b0; A = 32'd100; B = 32'd7;
    step();
    Start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!Done && lat < 100) begin
      if (Busy) busy_cnt++;
      step();
      lat++;
    end
    q = Quot; r = Rem; dz = DivZero;
    total++;
    if (lat !== 33) begin bad++; $display("FAIL unsigned_latency: got %0d want 33", lat); end
    total++;
    if (busy_cnt !== 33) begin bad++; $display("FAIL unsigned_busy: got %0d want 33", busy_cnt); end
    total++;
    if (q !== 32'd14 || r !== 32'd2 || dz !== 1'b0) begin
      bad++; $display("FAIL unsigned_100_7: got q=%0d r=%0d dz=%b want 14 2 0", q, r, dz);
    end
    step();
    total++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      bad++; $display("FAIL done_one_cycle: done=%b busy=%b want 0 0", Done, Busy);
    end
    total++;
    if (Quot !== 32'd14 || Rem !== 32'd2) begin
      bad++; $display("FAIL result_hold: got q=%0d r=%0d want 14 2", Quot, Rem);
    end
  endtask

  task automatic test_signed();
    logic [31:0] q, r; logic dz, da; int lat;
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, dz, lat, da);
    total++;
    if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF || lat !== 33) begin
      bad++; $display("FAIL signed_m7_2: got q=%h r=%h lat=%0d want fffffffd ffffffff 33", q, r, lat);
    end
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, dz, lat, da);
    total++;
    if (q !== 32'h8000_0000 || r !== 32'h0 || dz !== 1'b0) begin
      bad++; $display("FAIL signed_overflow: got q=%h r=%h dz=%b want 80000000 0 0", q, r, dz);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r; logic dz; int lat, busy_cnt;
    Start = 1'b1; Signed = 1'b0; A = 32'd5; B = 32'd0;
    step();
    Start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!Done && lat < 100) begin step(); lat++; end
    q = Quot; r = Rem; dz = DivZero;
    if (Busy) busy_cnt++;
    step();
    if (Busy) busy_cnt++;
    total++;
    if (lat !== 0 || busy_cnt !== 1) begin
      bad++; $display("FAIL divzero_timing: got lat=%0d busy_cycles=%0d want 0 1", lat, busy_cnt);
    end
    total++;
    if (q !== 32'hFFFF_FFFF || r !== 32'd5 || dz !== 1'b1) begin
      bad++; $display("FAIL divzero_result: got q=%h r=%0d dz=%b want ffffffff 5 1", q, r, dz);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er; logic sg, dz, edz, da; int lat, want_lat;
    for (int i = 0; i < 60; i++) begin
      a = $urandom(); b = $urandom(); sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = sg ? -32'($urandom_range(1, 15)) : b;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      ref_div(a, b, sg, eq, er, edz);
      want_lat = (b == 32'd0) ? 0 : 33;
      run_div(a, b, sg, q, r, dz, lat, da);
      total++;
      if (q !== eq || r !== er || dz !== edz || lat !== want_lat || da !== 1'b0) begin
        bad++;
        $display("FAIL random_%0d: a=%h b=%h s=%b got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                 i, a, b, sg, q, r, dz, lat, eq, er, edz, want_lat);
      end
    end
  endtask

  task automatic test_back_to_back_hazard();
    int cyc, stall_bad;
    Start = 1'b1; Signed = 1'b0; A = 32'd50; B = 32'd5;
    step();
    Start = 1'b0;
    cyc = 0; stall_bad = 0;
    while (!Done && cyc < 100) begin
      if (cyc == 10) begin
        Start = 1'b1; HiLoRead = 1'b1; A = 32'd1; B = 32'd1;
        #0;
      end
      if (cyc >= 10 && Stall !== 1'b1) stall_bad++;
      step();
      cyc++;
    end
    if (Stall !== 1'b1) stall_bad++;
    total++;
    if (stall_bad !== 0) begin bad++; $display("FAIL hazard_stall: %0d cycles without stall, want 0", stall_bad); end
    total++;
    if (Done !== 1'b1 || Quot !== 32'd10 || Rem !== 32'd0 || cyc !== 33) begin
      bad++; $display("FAIL hazard_result: got done=%b q=%0d r=%0d cyc=%0d want 1 10 0 33", Done, Quot, Rem, cyc);
    end
    step();
    total++;
    if (Busy !== 1'b0) begin bad++; $display("FAIL start_in_done_ignored: busy=%b want 0", Busy); end
    Start = 1'b0; HiLoRead = 1'b0;
    step();
  endtask

  task automatic test_flush();
    logic [31:0] q, r; logic dz, da; int lat, done_seen;
    Start = 1'b1; Signed = 1'b0; A = 32'd1000; B = 32'd3;
    step();
    Start = 1'b0;
    repeat (20) step();
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      bad++; $display("FAIL flush_calc: busy=%b done=%b want 0 0", Busy, Done);
    end
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (Done) done_seen++;
      step();
    end
    total++;
    if (done_seen !== 0 || Quot !== 32'd10 || Rem !== 32'd0) begin
      bad++; $display("FAIL flush_hold: done_pulses=%0d q=%0d r=%0d want 0 10 0", done_seen, Quot, Rem);
    end
    run_div(32'd9, 32'd3, 1'b0, q, r, dz, lat, da);
    total++;
    if (q !== 32'd3 || r !== 32'd0 || lat !== 33) begin
      bad++; $display("FAIL after_flush_9_3: got q=%0d r=%0d lat=%0d want 3 0 33", q, r, lat);
    end
    // Start and Flush together in IDLE: nothing starts.
    Start = 1'b1; Flush = 1'b1; A = 32'd8; B = 32'd0;
    step();
    Start = 1'b0; Flush = 1'b0;
    total++;
    if (Busy !== 1'b0 || DivZero !== 1'b0 || Quot !== 32'd3) begin
      bad++; $display("FAIL start_flush_idle: busy=%b dz=%b q=%0d want 0 0 3", Busy, DivZero, Quot);
    end
    // Flush during DONE still commits and returns to IDLE.
    Start = 1'b1; A = 32'd77; B = 32'd0;
    step();
    Start = 1'b0; Flush = 1'b1;
    #1;
    total++;
    if (Done !== 1'b1 || Quot !== 32'hFFFF_FFFF || Rem !== 32'd77 || DivZero !== 1'b1) begin
      bad++; $display("FAIL flush_in_done: done=%b q=%h r=%0d dz=%b want 1 ffffffff 77 1", Done, Quot, Rem, DivZero);
    end
    step();
    Flush = 1'b0;
    total++;
    if (Busy !== 1'b0) begin bad++; $display("FAIL flush_in_done_idle: busy=%b want 0", Busy); end
  endtask

  task automatic test_async_reset();
    logic [31:0] q, r; logic dz, da; int lat, done_seen;
    Start = 1'b1; Signed = 1'b0; A = 32'd1000; B = 32'd7;
    step();
    Start = 1'b0;
    repeat (15) step();
    HiLoRead = 1'b1;
    #2;
    nReset = 1'b0;
    #1;
    total++;
    if (Busy !== 1'b0 || Quot !== 32'd0 || Rem !== 32'd0 || Stall !== 1'b0 || DivZero !== 1'b0) begin
      bad++; $display("FAIL async_reset: busy=%b q=%h r=%h stall=%b dz=%b want all 0", Busy, Quot, Rem, Stall, DivZero);
    end
    HiLoRead = 1'b0;
    step();
    #2;
    nReset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (Done || Busy) done_seen++;
    end
    total++;
    if (done_seen !== 0) begin bad++; $display("FAIL reset_discard: %0d active cycles want 0", done_seen); end
    run_div(32'd1000, 32'd7, 1'b0, q, r, dz, lat, da);
    total++;
    if (q !== 32'd142 || r !== 32'd6 || lat !== 33) begin
      bad++; $display("FAIL after_reset_div: got q=%0d r=%0d lat=%0d want 142 6 33", q, r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_random();
    test_back_to_back_hazard();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
